// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with runtime baud divisor and frame format.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over consecutive ticks.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RxD,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);
   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BI_W = $clog2(DATA_BITS);
   localparam logic [SC_W-1:0]  SC_ZERO = {SC_W{1'b0}};
   localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
   localparam logic [SC_W-1:0]  SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(OVERSAMPLE - 1);
   localparam logic [BI_W-1:0]  BI_ZERO = {BI_W{1'b0}};
   localparam logic [BI_W-1:0]  BI_ONE  = BI_W'(1);
   localparam logic [BI_W-1:0]  BI_LAST = BI_W'(DATA_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

`ifdef UART_RX_MAJORITY_EN
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
`endif

   logic                 sync1_q, sync1_d;
   logic                 rxs_q, rxs_d;
   logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0]     div_m1_s;
   logic                 tick_s;
   logic                 bit_s;
   state_t               state_q, state_d;
   logic [SC_W-1:0]      sc_q, sc_d;
   logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 fmt_par_en_q, fmt_par_en_d;
   logic                 fmt_par_odd_q, fmt_par_odd_d;
   logic                 fmt_stop2_q, fmt_stop2_d;
   logic                 pend_perr_q, pend_perr_d;
   logic                 pend_ferr_q, pend_ferr_d;
   logic                 commit_s;
   logic                 commit_ferr_s;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 busy_q, busy_d;

   // Synchroniser and free-running baud tick generator; a divisor of 0 behaves as 1.
   always_comb begin
      sync1_d    = RxD;
      rxs_d      = sync1_q;
      div_m1_s   = (baud_div == DIV_ZERO) ? DIV_ZERO : (baud_div - DIV_ONE);
      tick_s     = (baud_cnt_q >= div_m1_s);
      baud_cnt_d = tick_s ? DIV_ZERO : (baud_cnt_q + DIV_ONE);
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q, hist_d;

   // History holds rxs from the two ticks preceding the current one.
   always_comb begin
      hist_d = tick_s ? {hist_q[0], rxs_q} : hist_q;
      bit_s  = maj3(rxs_q, hist_q[0], hist_q[1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   always_comb begin
      bit_s = rxs_q;
   end
`endif

   // Frame sequencer: all decisions happen on ticks at the configured sample points.
   always_comb begin
      state_d       = state_q;
      sc_d          = sc_q;
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      stop_idx_d    = stop_idx_q;
      fmt_par_en_d  = fmt_par_en_q;
      fmt_par_odd_d = fmt_par_odd_q;
      fmt_stop2_d   = fmt_stop2_q;
      pend_perr_d   = pend_perr_q;
      pend_ferr_d   = pend_ferr_q;
      commit_s      = 1'b0;
      commit_ferr_s = pend_ferr_q;
      case (state_q)
         S_IDLE: begin
            if (tick_s && !rxs_q) begin
               state_d       = S_START;
               sc_d          = SC_ZERO;
               bit_idx_d     = BI_ZERO;
               stop_idx_d    = 1'b0;
               fmt_par_en_d  = parity_en;
               fmt_par_odd_d = parity_odd;
               fmt_stop2_d   = stop2;
               pend_perr_d   = 1'b0;
               pend_ferr_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (tick_s && (sc_q == SC_HALF)) begin
               if (bit_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  sc_d      = SC_ZERO;
                  bit_idx_d = BI_ZERO;
               end
            end else if (tick_s) begin
               sc_d = sc_q + SC_ONE;
            end else begin
               sc_d = sc_q;
            end
         end
         S_DATA: begin
            if (tick_s && (sc_q == SC_LAST)) begin
               shreg_d   = {bit_s, shreg_q[DATA_BITS-1:1]};
               sc_d      = SC_ZERO;
               bit_idx_d = bit_idx_q + BI_ONE;
               if (bit_idx_q == BI_LAST) begin
                  state_d    = fmt_par_en_q ? S_PARITY : S_STOP;
                  stop_idx_d = 1'b0;
               end else begin
                  state_d = S_DATA;
               end
            end else if (tick_s) begin
               sc_d = sc_q + SC_ONE;
            end else begin
               sc_d = sc_q;
            end
         end
         S_PARITY: begin
            if (tick_s && (sc_q == SC_LAST)) begin
               if (bit_s != exp_parity(shreg_q, fmt_par_odd_q)) begin
                  pend_perr_d = 1'b1;
               end else begin
                  pend_perr_d = pend_perr_q;
               end
               sc_d    = SC_ZERO;
               state_d = S_STOP;
            end else if (tick_s) begin
               sc_d = sc_q + SC_ONE;
            end else begin
               sc_d = sc_q;
            end
         end
         S_STOP: begin
            if (tick_s && (sc_q == SC_LAST)) begin
               sc_d        = SC_ZERO;
               pend_ferr_d = pend_ferr_q | ~bit_s;
               if (fmt_stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  // Leaving mid-stop lets an immediately following start bit be caught.
                  commit_s      = 1'b1;
                  commit_ferr_s = pend_ferr_q | ~bit_s;
                  state_d       = S_IDLE;
               end
            end else if (tick_s) begin
               sc_d = sc_q + SC_ONE;
            end else begin
               sc_d = sc_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            sc_d    = SC_ZERO;
         end
      endcase
   end

   // Holding register: a commit beats a simultaneous acknowledge.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ovr_d      = ovr_q;
      busy_d     = (state_d != S_IDLE);
      if (commit_s && (!rx_valid_q || rx_ack)) begin
         rx_data_d  = shreg_q;
         rx_valid_d = 1'b1;
         perr_d     = pend_perr_q;
         ferr_d     = commit_ferr_s;
         ovr_d      = rx_ack ? 1'b0 : ovr_q;
      end else if (commit_s) begin
         ovr_d = 1'b1;
      end else if (rx_ack) begin
         rx_valid_d = 1'b0;
         perr_d     = 1'b0;
         ferr_d     = 1'b0;
         ovr_d      = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= 1'b1;
         rxs_q         <= 1'b1;
         baud_cnt_q    <= DIV_ZERO;
         state_q       <= S_IDLE;
         sc_q          <= SC_ZERO;
         bit_idx_q     <= BI_ZERO;
         shreg_q       <= {DATA_BITS{1'b0}};
         stop_idx_q    <= 1'b0;
         fmt_par_en_q  <= 1'b0;
         fmt_par_odd_q <= 1'b0;
         fmt_stop2_q   <= 1'b0;
         pend_perr_q   <= 1'b0;
         pend_ferr_q   <= 1'b0;
         rx_data_q     <= {DATA_BITS{1'b0}};
         rx_valid_q    <= 1'b0;
         perr_q        <= 1'b0;
         ferr_q        <= 1'b0;
         ovr_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         rxs_q         <= rxs_d;
         baud_cnt_q    <= baud_cnt_d;
         state_q       <= state_d;
         sc_q          <= sc_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         stop_idx_q    <= stop_idx_d;
         fmt_par_en_q  <= fmt_par_en_d;
         fmt_par_odd_q <= fmt_par_odd_d;
         fmt_stop2_q   <= fmt_stop2_d;
         pend_perr_q   <= pend_perr_d;
         pend_ferr_q   <= pend_ferr_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         perr_q        <= perr_d;
         ferr_q        <= ferr_d;
         ovr_q         <= ovr_d;
         busy_q        <= busy_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = ovr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit and a 7-bit receiver share one serial line.
`timescale 1ns/1ps
module tb_uart_rx_param;
   localparam int DIV = 27;
   localparam int OS  = 16;
   localparam int BIT = DIV * OS;

   logic        clk = 1'b0;
   logic        reset;
   logic        rxd;
   logic [15:0] baud_div;
   logic        parity_en, parity_odd, stop2, rx_ack;
   logic [7:0]  d8;
   logic        v8, pe8, fe8, oe8, busy8;
   logic [6:0]  d7;
   logic        v7, pe7, fe7, oe7, busy7;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .DIV_W(16)) dut8 (
      .clk(clk), .reset(reset), .RxD(rxd), .baud_div(baud_div),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx_ack(rx_ack),
      .rx_data(d8), .rx_valid(v8), .parity_err(pe8), .frame_err(fe8),
      .overrun_err(oe8), .busy(busy8));

   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .DIV_W(16)) dut7 (
      .clk(clk), .reset(reset), .RxD(rxd), .baud_div(baud_div),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx_ack(rx_ack),
      .rx_data(d7), .rx_valid(v7), .parity_err(pe7), .frame_err(fe7),
      .overrun_err(oe7), .busy(busy7));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input logic glitch);
      if (glitch) begin
         rxd = v;  repeat (BIT / 2) @(negedge clk);
         rxd = ~v; repeat (DIV) @(negedge clk);
         rxd = v;  repeat (BIT - BIT / 2 - DIV) @(negedge clk);
      end else begin
         rxd = v;  repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [8:0] data, input int nbits, input logic use_par,
                             input logic par_bit, input logic stop_a, input logic use_stop2,
                             input logic stop_b, input int glitch_bit);
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(data[i], i == glitch_bit);
      if (use_par) drive_bit(par_bit, 1'b0);
      drive_bit(stop_a, 1'b0);
      if (use_stop2) drive_bit(stop_b, 1'b0);
      rxd = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * BIT) @(negedge clk);
   endtask

   task automatic ack_pulse();
      @(negedge clk); rx_ack = 1'b1;
      @(negedge clk); rx_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rxd = 1'b1; baud_div = 16'd27;
      parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; rx_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_data", d8, 8'h00);
      chk("rst_valid", v8, 1'b0);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_errs", {pe8, fe8, oe8}, 3'b000);
      reset = 1'b0;
      idle_bits(1);

      // 8N1 basic frame and acknowledge
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      chk("t1_valid", v8, 1'b1);
      chk("t1_data", d8, 8'hA5);
      chk("t1_errs", {pe8, fe8, oe8}, 3'b000);
      chk("t1_busy", busy8, 1'b0);
      ack_pulse();
      chk("t1_ack_valid", v8, 1'b0);

      // Even parity mismatch, then odd parity match
      parity_en = 1'b1; parity_odd = 1'b0;
      send_frame(9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      chk("t2_data", d8, 8'h3C);
      chk("t2_perr", pe8, 1'b1);
      chk("t2_ferr", fe8, 1'b0);
      ack_pulse();
      chk("t2_ack_perr", pe8, 1'b0);
      parity_odd = 1'b1;
      send_frame(9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      chk("t2_odd_data", d8, 8'h3C);
      chk("t2_odd_perr", pe8, 1'b0);
      ack_pulse();
      parity_en = 1'b0; parity_odd = 1'b0;

      // Framing error, line recovers, next frame accepted after ack
      send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle_bits(2);
      chk("t3_data", d8, 8'h55);
      chk("t3_ferr", fe8, 1'b1);
      chk("t3_valid", v8, 1'b1);
      chk("t3_busy", busy8, 1'b0);
      ack_pulse();
      chk("t3_ack_ferr", fe8, 1'b0);
      send_frame(9'h012, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      chk("t3_next_data", d8, 8'h12);
      chk("t3_next_ferr", fe8, 1'b0);
      ack_pulse();

      // False start: 5 ticks low
      rxd = 1'b0;
      repeat (5 * DIV) @(negedge clk);
      rxd = 1'b1;
      chk("t4_busy_in_start", busy8, 1'b1);
      repeat (12 * DIV) @(negedge clk);
      chk("t4_busy_back", busy8, 1'b0);
      chk("t4_valid", v8, 1'b0);

`ifdef UART_RX_MAJORITY_EN
      send_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
      chk("t4_glitch_data", d8, 8'hFF);
      ack_pulse();
`endif

      // Back-to-back overrun, then ack coinciding with commit
      send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      chk("t5_data", d8, 8'h11);
      chk("t5_valid", v8, 1'b1);
      chk("t5_ovr", oe8, 1'b1);
      fork
         send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
         begin
            int n;
            n = 0;
            while (!busy8 && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("t5_busy_rise", busy8, 1'b1);
            // start detect edge to commit edge is 152 ticks of DIV clocks
            repeat (152 * DIV - 1) @(posedge clk);
            @(negedge clk); rx_ack = 1'b1;
            @(negedge clk); rx_ack = 1'b0;
         end
      join
      chk("t5_ack_data", d8, 8'h33);
      chk("t5_ack_valid", v8, 1'b1);
      chk("t5_ack_ovr", oe8, 1'b0);
      ack_pulse();

      // 7-bit, two stop bits, asynchronous reset mid-DATA
      stop2 = 1'b1;
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk); reset = 1'b0;
      idle_bits(1);
      send_frame(9'h05A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
      chk("t6_pre_data", d7, 7'h5A);
      chk("t6_pre_valid", v7, 1'b1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      chk("t6_busy_mid", busy7, 1'b1);
      reset = 1'b1;
      #1;
      chk("t6_rst_data", d7, 7'h00);
      chk("t6_rst_valid", v7, 1'b0);
      chk("t6_rst_busy", busy7, 1'b0);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle_bits(1);
      send_frame(9'h05A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
      chk("t6_data", d7, 7'h5A);
      chk("t6_valid", v7, 1'b1);
      chk("t6_errs", {pe7, fe7, oe7}, 3'b000);
      ack_pulse();
      send_frame(9'h021, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      idle_bits(2);
      chk("t6_stop2_data", d7, 7'h21);
      chk("t6_stop2_ferr", fe7, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
